// File: rtl/soc_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : soc_bus_fabric
// Brief    : Single-master to NUM_SLV-slave address decoder with independent
//            read/write channels, busy stall and first-error capture.
// Revision : 1.0
// ============================================================================
module soc_bus_fabric #(
   parameter int                        NUM_SLV  = 4,
   parameter int                        DATA_W   = 32,
   parameter int                        ADDR_W   = 32,
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                    32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {NUM_SLV{32'hF000_0000}},
   parameter logic [DATA_W-1:0]         ERR_DATA = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        m_rd_req_i,
   input  logic                        m_wr_req_i,
   input  logic [ADDR_W-1:0]           m_rd_addr_i,
   input  logic [ADDR_W-1:0]           m_wr_addr_i,
   input  logic [3:0]                  m_wr_sel_i,
   input  logic [DATA_W-1:0]           m_wr_data_i,
   output logic [DATA_W-1:0]           m_rd_data_o,
   output logic                        m_rd_vld_o,
   output logic                        m_stall_o,
   output logic [NUM_SLV-1:0]          s_rd_req_o,
   output logic [NUM_SLV-1:0]          s_wr_req_o,
   output logic [ADDR_W-1:0]           s_rd_addr_o,
   output logic [ADDR_W-1:0]           s_wr_addr_o,
   output logic [3:0]                  s_wr_sel_o,
   output logic [DATA_W-1:0]           s_wr_data_o,
   input  logic [NUM_SLV*DATA_W-1:0]   s_rd_data_i,
   input  logic [NUM_SLV-1:0]          s_busy_i,
   output logic                        err_o,
   output logic [1:0]                  err_type_o,
   output logic [ADDR_W-1:0]           err_addr_o,
   output logic [7:0]                  err_cnt_o,
   input  logic                        err_clr_i
);

   localparam int c_IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

   logic [NUM_SLV-1:0] w_rd_hit;
   logic [NUM_SLV-1:0] w_wr_hit;
   logic [NUM_SLV-1:0] w_rd_sel;
   logic [NUM_SLV-1:0] w_wr_sel;
   logic               w_rd_map;
   logic               w_wr_map;
   logic               w_rd_busy;
   logic               w_wr_busy;
   logic               w_rd_acc;
   logic               w_wr_acc;
   logic               w_rd_err;
   logic               w_wr_err;
   logic               w_any_err;
   logic [c_IDX_W-1:0] w_rd_idx;
   logic [DATA_W-1:0]  w_rd_mux;
   logic [7:0]         w_cnt_inc;

   logic               r_rd_vld;
   logic               r_rd_unmap;
   logic [c_IDX_W-1:0] r_rd_idx;
   logic [DATA_W-1:0]  r_rd_hold;
   logic               r_err;
   logic [1:0]         r_err_type;
   logic [ADDR_W-1:0]  r_err_addr;
   logic [7:0]         r_err_cnt;

   generate
      for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_dec
         assign w_rd_hit[gi] = ((m_rd_addr_i & SLV_MASK[gi*ADDR_W +: ADDR_W])
                                == SLV_BASE[gi*ADDR_W +: ADDR_W]);
         assign w_wr_hit[gi] = ((m_wr_addr_i & SLV_MASK[gi*ADDR_W +: ADDR_W])
                                == SLV_BASE[gi*ADDR_W +: ADDR_W]);
      end
   endgenerate

   // Isolate the lowest set hit bit so the lowest slave index wins overlaps.
   assign w_rd_sel  = w_rd_hit & (~w_rd_hit + NUM_SLV'(1));
   assign w_wr_sel  = w_wr_hit & (~w_wr_hit + NUM_SLV'(1));
   assign w_rd_map  = |w_rd_hit;
   assign w_wr_map  = |w_wr_hit;
   assign w_rd_busy = |(w_rd_sel & s_busy_i);
   assign w_wr_busy = |(w_wr_sel & s_busy_i);

   assign m_stall_o = (m_rd_req_i & w_rd_busy) | (m_wr_req_i & w_wr_busy);
   assign w_rd_acc  = m_rd_req_i & ~m_stall_o;
   assign w_wr_acc  = m_wr_req_i & ~m_stall_o;
   assign w_rd_err  = w_rd_acc & ~w_rd_map;
   assign w_wr_err  = w_wr_acc & ~w_wr_map;
   assign w_any_err = w_rd_err | w_wr_err;

   assign s_rd_req_o  = w_rd_acc ? w_rd_sel : '0;
   assign s_wr_req_o  = w_wr_acc ? w_wr_sel : '0;
   assign s_rd_addr_o = m_rd_addr_i;
   assign s_wr_addr_o = m_wr_addr_i;
   assign s_wr_sel_o  = m_wr_sel_i;
   assign s_wr_data_o = m_wr_data_i;

   always_comb begin
      w_rd_idx = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (w_rd_sel[i]) begin
            w_rd_idx = w_rd_idx | c_IDX_W'(i);
         end
      end
   end

   always_comb begin
      w_rd_mux = ERR_DATA;
      if (!r_rd_unmap) begin
         for (int i = 0; i < NUM_SLV; i++) begin
            if (r_rd_idx == c_IDX_W'(i)) begin
               w_rd_mux = s_rd_data_i[i*DATA_W +: DATA_W];
            end
         end
      end
   end

   // Valid cycle shows the live slave word; otherwise the last delivered word.
   assign m_rd_data_o = r_rd_vld ? w_rd_mux : r_rd_hold;
   assign m_rd_vld_o  = r_rd_vld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_vld   <= 1'b0;
         r_rd_unmap <= 1'b0;
         r_rd_idx   <= '0;
         r_rd_hold  <= '0;
      end else begin
         r_rd_vld <= w_rd_acc;
         if (w_rd_acc) begin
            r_rd_unmap <= ~w_rd_map;
            r_rd_idx   <= w_rd_idx;
         end
         if (r_rd_vld) begin
            r_rd_hold <= w_rd_mux;
         end
      end
   end

   assign w_cnt_inc = (r_err_cnt == 8'hFF) ? 8'hFF : r_err_cnt + 8'd1;

   // A clear coinciding with a new error restarts capture with that error.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err      <= 1'b0;
         r_err_type <= 2'b00;
         r_err_addr <= '0;
         r_err_cnt  <= 8'd0;
      end else if (w_any_err && (!r_err || err_clr_i)) begin
         r_err      <= 1'b1;
         r_err_type <= {w_wr_err, w_rd_err};
         r_err_addr <= w_rd_err ? m_rd_addr_i : m_wr_addr_i;
         r_err_cnt  <= err_clr_i ? 8'd1 : w_cnt_inc;
      end else if (err_clr_i) begin
         r_err      <= 1'b0;
         r_err_type <= 2'b00;
         r_err_addr <= '0;
         r_err_cnt  <= 8'd0;
      end else if (w_any_err) begin
         r_err_cnt  <= w_cnt_inc;
      end
   end

   assign err_o      = r_err;
   assign err_type_o = r_err_type;
   assign err_addr_o = r_err_addr;
   assign err_cnt_o  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_soc_bus_fabric.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_bus_fabric
// Brief    : Directed and randomized self-checking bench for soc_bus_fabric.
// Revision : 1.0
// ============================================================================
module tb_soc_bus_fabric;

   localparam int          NUM_SLV = 4;
   localparam int          DATA_W  = 32;
   localparam int          ADDR_W  = 32;
   localparam logic [31:0] c_ERR   = 32'hDEAD_BEEF;
   localparam logic [31:0] c_MASK  = 32'hF000_0000;

   logic [31:0] c_base [NUM_SLV];

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      m_rd_req, m_wr_req;
   logic [ADDR_W-1:0]         m_rd_addr, m_wr_addr;
   logic [3:0]                m_wr_sel;
   logic [DATA_W-1:0]         m_wr_data;
   logic [DATA_W-1:0]         m_rd_data;
   logic                      m_rd_vld, m_stall;
   logic [NUM_SLV-1:0]        s_rd_req, s_wr_req;
   logic [ADDR_W-1:0]         s_rd_addr, s_wr_addr;
   logic [3:0]                s_wr_sel;
   logic [DATA_W-1:0]         s_wr_data;
   logic [DATA_W-1:0]         slv_data [NUM_SLV];
   logic [NUM_SLV*DATA_W-1:0] s_rd_data;
   logic [NUM_SLV-1:0]        s_busy;
   logic                      err, err_clr;
   logic [1:0]                err_type;
   logic [ADDR_W-1:0]         err_addr;
   logic [7:0]                err_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   assign s_rd_data = {slv_data[3], slv_data[2], slv_data[1], slv_data[0]};

   soc_bus_fabric #(.NUM_SLV(NUM_SLV), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ERR_DATA(c_ERR)) dut (
      .clk(clk), .rst(rst),
      .m_rd_req_i(m_rd_req), .m_wr_req_i(m_wr_req),
      .m_rd_addr_i(m_rd_addr), .m_wr_addr_i(m_wr_addr),
      .m_wr_sel_i(m_wr_sel), .m_wr_data_i(m_wr_data),
      .m_rd_data_o(m_rd_data), .m_rd_vld_o(m_rd_vld), .m_stall_o(m_stall),
      .s_rd_req_o(s_rd_req), .s_wr_req_o(s_wr_req),
      .s_rd_addr_o(s_rd_addr), .s_wr_addr_o(s_wr_addr),
      .s_wr_sel_o(s_wr_sel), .s_wr_data_o(s_wr_data),
      .s_rd_data_i(s_rd_data), .s_busy_i(s_busy),
      .err_o(err), .err_type_o(err_type), .err_addr_o(err_addr), .err_cnt_o(err_cnt),
      .err_clr_i(err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NUM_SLV; i++)
         if ((a & c_MASK) == c_base[i]) return i;
      return -1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      m_rd_req = 0; m_wr_req = 0; m_rd_addr = '0; m_wr_addr = '0;
      m_wr_sel = '0; m_wr_data = '0; s_busy = '0; err_clr = 0;
   endtask

   task automatic clear_err;
      idle();
      err_clr = 1;
      tick();
      err_clr = 0;
   endtask

   task automatic test_reset;
      rst = 0;
      idle();
      for (int i = 0; i < NUM_SLV; i++) slv_data[i] = 32'h1111_0000 * (i + 1);
      m_rd_req = 1; m_rd_addr = 32'h1000_0000;
      #3;
      n_chk++; if (m_rd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b expected 0", m_rd_vld); end
      n_chk++; if (m_rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", m_rd_data); end
      n_chk++; if ({err, err_type, err_cnt} !== 11'h0) begin n_fail++; $display("FAIL reset_err: got %b/%b/%h expected 0", err, err_type, err_cnt); end
      n_chk++; if (err_addr !== 32'h0) begin n_fail++; $display("FAIL reset_err_addr: got %h expected 0", err_addr); end
      n_chk++; if (s_rd_req !== 4'b0010) begin n_fail++; $display("FAIL reset_comb_req: got %b expected 0010", s_rd_req); end
      repeat (2) @(posedge clk);
      #1 rst = 1;
      idle();
      tick();
      n_chk++; if (m_rd_vld !== 1'b0) begin n_fail++; $display("FAIL reset_release_vld: got %b expected 0", m_rd_vld); end
   endtask

   task automatic test_read_basic;
      idle();
      slv_data[1] = 32'hCAFE_F00D;
      m_rd_req = 1; m_rd_addr = 32'h1000_0004;
      #1;
      n_chk++; if (s_rd_req !== 4'b0010) begin n_fail++; $display("FAIL rd_req_onehot: got %b expected 0010", s_rd_req); end
      n_chk++; if (m_stall !== 1'b0) begin n_fail++; $display("FAIL rd_stall: got %b expected 0", m_stall); end
      tick();
      m_rd_req = 0;
      n_chk++; if (m_rd_vld !== 1'b1) begin n_fail++; $display("FAIL rd_vld: got %b expected 1", m_rd_vld); end
      n_chk++; if (m_rd_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd_data: got %h expected cafef00d", m_rd_data); end
      tick();
      slv_data[1] = 32'h0BAD_0BAD;
      #1;
      n_chk++; if (m_rd_vld !== 1'b0) begin n_fail++; $display("FAIL rd_vld_clear: got %b expected 0", m_rd_vld); end
      n_chk++; if (m_rd_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd_data_hold: got %h expected cafef00d", m_rd_data); end
   endtask

   task automatic test_dual;
      idle();
      m_wr_req = 1; m_wr_addr = 32'h2000_0000; m_wr_sel = 4'hA; m_wr_data = 32'h1234_5678;
      m_rd_req = 1; m_rd_addr = 32'h0000_0010;
      #1;
      n_chk++; if (s_wr_req !== 4'b0100) begin n_fail++; $display("FAIL dual_wr_req: got %b expected 0100", s_wr_req); end
      n_chk++; if (s_rd_req !== 4'b0001) begin n_fail++; $display("FAIL dual_rd_req: got %b expected 0001", s_rd_req); end
      n_chk++; if (m_stall !== 1'b0) begin n_fail++; $display("FAIL dual_stall: got %b expected 0", m_stall); end
      n_chk++; if ({s_wr_addr, s_wr_sel, s_wr_data} !== {32'h2000_0000, 4'hA, 32'h1234_5678}) begin
         n_fail++; $display("FAIL dual_broadcast: got %h/%h/%h expected 20000000/a/12345678", s_wr_addr, s_wr_sel, s_wr_data); end
      tick();
      idle();
      n_chk++; if (m_rd_data !== slv_data[0]) begin n_fail++; $display("FAIL dual_rd_data: got %h expected %h", m_rd_data, slv_data[0]); end
   endtask

   task automatic test_stall;
      idle();
      tick();
      s_busy = 4'b0001;
      m_rd_req = 1; m_rd_addr = 32'h0000_0000;
      m_wr_req = 1; m_wr_addr = 32'h9000_0000;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_chk++; if (m_stall !== 1'b1) begin n_fail++; $display("FAIL stall_cycle%0d: got %b expected 1", k, m_stall); end
         n_chk++; if ({s_rd_req, s_wr_req} !== 8'h0) begin n_fail++; $display("FAIL stall_req%0d: got %b/%b expected 0", k, s_rd_req, s_wr_req); end
         tick();
         n_chk++; if (m_rd_vld !== 1'b0) begin n_fail++; $display("FAIL stall_vld%0d: got %b expected 0", k, m_rd_vld); end
      end
      n_chk++; if ({err, err_cnt} !== 9'h0) begin n_fail++; $display("FAIL stall_no_err: got %b/%h expected 0", err, err_cnt); end
      s_busy = 4'b0000; m_wr_req = 0;
      #1;
      n_chk++; if ({m_stall, s_rd_req} !== 5'b0_0001) begin n_fail++; $display("FAIL stall_grant: got %b/%b expected 0/0001", m_stall, s_rd_req); end
      tick();
      m_rd_req = 0;
      n_chk++; if ({m_rd_vld, m_rd_data} !== {1'b1, slv_data[0]}) begin n_fail++; $display("FAIL stall_data: got %b/%h expected 1/%h", m_rd_vld, m_rd_data, slv_data[0]); end
      s_busy = 4'b0100;
      m_wr_req = 1; m_wr_addr = 32'h2000_0040;
      m_rd_req = 1; m_rd_addr = 32'h1000_0000;
      #1;
      n_chk++; if ({m_stall, s_rd_req, s_wr_req} !== 9'b1_0000_0000) begin n_fail++; $display("FAIL stall_wr_busy: got %b/%b/%b expected 1/0/0", m_stall, s_rd_req, s_wr_req); end
      tick();
      idle();
   endtask

   task automatic test_errors;
      clear_err();
      m_rd_req = 1; m_rd_addr = 32'h5000_0000;
      #1;
      n_chk++; if ({m_stall, s_rd_req} !== 5'h0) begin n_fail++; $display("FAIL unmapped_rd_req: got %b/%b expected 0", m_stall, s_rd_req); end
      tick();
      m_rd_req = 0; m_wr_req = 1; m_wr_addr = 32'h6000_0000;
      n_chk++; if ({m_rd_vld, m_rd_data} !== {1'b1, c_ERR}) begin n_fail++; $display("FAIL err_data: got %b/%h expected 1/%h", m_rd_vld, m_rd_data, c_ERR); end
      n_chk++; if ({err, err_type, err_addr, err_cnt} !== {1'b1, 2'b01, 32'h5000_0000, 8'd1}) begin
         n_fail++; $display("FAIL err_first: got %b/%b/%h/%0d expected 1/01/50000000/1", err, err_type, err_addr, err_cnt); end
      #1;
      n_chk++; if (s_wr_req !== 4'b0) begin n_fail++; $display("FAIL unmapped_wr_req: got %b expected 0", s_wr_req); end
      tick();
      idle();
      n_chk++; if ({err, err_type, err_addr, err_cnt} !== {1'b1, 2'b01, 32'h5000_0000, 8'd2}) begin
         n_fail++; $display("FAIL err_frozen: got %b/%b/%h/%0d expected 1/01/50000000/2", err, err_type, err_addr, err_cnt); end
      clear_err();
      n_chk++; if ({err, err_type, err_addr, err_cnt} !== 43'h0) begin
         n_fail++; $display("FAIL err_clear: got %b/%b/%h/%0d expected 0", err, err_type, err_addr, err_cnt); end
      m_rd_req = 1; m_rd_addr = 32'h8000_0000;
      m_wr_req = 1; m_wr_addr = 32'h9000_0000;
      tick();
      idle();
      n_chk++; if ({err, err_type, err_addr, err_cnt} !== {1'b1, 2'b11, 32'h8000_0000, 8'd1}) begin
         n_fail++; $display("FAIL err_both: got %b/%b/%h/%0d expected 1/11/80000000/1", err, err_type, err_addr, err_cnt); end
      clear_err();
   endtask

   task automatic test_clr_coincident;
      idle();
      m_rd_req = 1; m_rd_addr = 32'hA000_0000;
      tick();
      idle();
      err_clr = 1; m_wr_req = 1; m_wr_addr = 32'h7000_0000;
      tick();
      idle();
      n_chk++; if ({err, err_type, err_addr, err_cnt} !== {1'b1, 2'b10, 32'h7000_0000, 8'd1}) begin
         n_fail++; $display("FAIL clr_coincident: got %b/%b/%h/%0d expected 1/10/70000000/1", err, err_type, err_addr, err_cnt); end
      clear_err();
   endtask

   task automatic test_saturation;
      idle();
      m_rd_req = 1; m_rd_addr = 32'hC000_0000;
      tick();
      m_rd_addr = 32'hD000_0000;
      repeat (253) tick();
      n_chk++; if (err_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", err_cnt); end
      repeat (6) tick();
      idle();
      n_chk++; if ({err_cnt, err_addr} !== {8'hFF, 32'hC000_0000}) begin n_fail++; $display("FAIL sat_ff: got %h/%h expected ff/c0000000", err_cnt, err_addr); end
      clear_err();
   endtask

   task automatic test_random;
      int          e_vld, e_pend, e_err, e_cnt;
      logic [1:0]  e_type;
      logic [31:0] e_addr, e_last;
      int          ri, wi;
      logic        e_stall, racc, wacc, rerr, werr;
      logic [3:0]  e_srd, e_swr;
      idle();
      m_rd_req = 1; m_rd_addr = 32'h0000_0100;
      tick();
      idle();
      e_last = slv_data[0];
      tick();
      e_vld = 0; e_pend = 0; e_err = 0; e_cnt = 0; e_type = 0; e_addr = 0;
      for (int b = 0; b < 8; b++) begin
         for (int j = 0; j < 60; j++) begin
            if (j == 1) for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
            m_rd_req  = (j != 0) && ($urandom_range(0, 1) == 1);
            m_wr_req  = $urandom_range(0, 1) == 1;
            m_rd_addr = {4'($urandom_range(0, 7)), 28'($urandom)};
            m_wr_addr = {4'($urandom_range(0, 7)), 28'($urandom)};
            m_wr_sel  = 4'($urandom);
            m_wr_data = $urandom;
            s_busy    = 4'($urandom) & 4'($urandom);
            err_clr   = $urandom_range(0, 19) == 0;
            #1;
            ri = decode(m_rd_addr);
            wi = decode(m_wr_addr);
            e_stall = (m_rd_req && ri >= 0 && s_busy[ri]) || (m_wr_req && wi >= 0 && s_busy[wi]);
            racc = m_rd_req && !e_stall;
            wacc = m_wr_req && !e_stall;
            e_srd = (racc && ri >= 0) ? 4'(1 << ri) : 4'h0;
            e_swr = (wacc && wi >= 0) ? 4'(1 << wi) : 4'h0;
            n_chk++; if ({m_stall, s_rd_req, s_wr_req} !== {e_stall, e_srd, e_swr}) begin
               n_fail++; $display("FAIL rnd_comb b%0d c%0d: got %b/%b/%b expected %b/%b/%b", b, j, m_stall, s_rd_req, s_wr_req, e_stall, e_srd, e_swr); end
            n_chk++; if ({s_rd_addr, s_wr_addr, s_wr_sel, s_wr_data} !== {m_rd_addr, m_wr_addr, m_wr_sel, m_wr_data}) begin
               n_fail++; $display("FAIL rnd_broadcast b%0d c%0d: got %h/%h expected %h/%h", b, j, s_rd_addr, s_wr_addr, m_rd_addr, m_wr_addr); end
            rerr = racc && ri < 0;
            werr = wacc && wi < 0;
            if (err_clr) begin e_err = 0; e_type = 0; e_addr = 0; e_cnt = 0; end
            if (rerr || werr) begin
               if (e_err == 0) begin
                  e_err = 1; e_type = {werr, rerr}; e_addr = rerr ? m_rd_addr : m_wr_addr;
               end
               if (e_cnt < 255) e_cnt++;
            end
            e_vld = racc ? 1 : 0;
            if (racc) e_pend = ri;
            tick();
            if (e_vld == 1) e_last = (e_pend < 0) ? c_ERR : slv_data[e_pend];
            n_chk++; if ({m_rd_vld, m_rd_data} !== {e_vld[0], e_last}) begin
               n_fail++; $display("FAIL rnd_read b%0d c%0d: got %b/%h expected %b/%h", b, j, m_rd_vld, m_rd_data, e_vld[0], e_last); end
            n_chk++; if ({err, err_type, err_addr, err_cnt} !== {e_err[0], e_type, e_addr, 8'(e_cnt)}) begin
               n_fail++; $display("FAIL rnd_err b%0d c%0d: got %b/%b/%h/%0d expected %b/%b/%h/%0d", b, j, err, err_type, err_addr, err_cnt, e_err[0], e_type, e_addr, e_cnt); end
         end
      end
      idle();
      tick();
   endtask

   task automatic test_reset_inflight;
      idle();
      m_rd_req = 1; m_rd_addr = 32'hB000_0000;
      tick();
      m_rd_addr = 32'h1000_0000;
      #2 rst = 0;
      #1;
      n_chk++; if ({m_rd_vld, m_rd_data} !== 33'h0) begin n_fail++; $display("FAIL inflight_rd: got %b/%h expected 0/0", m_rd_vld, m_rd_data); end
      n_chk++; if ({err, err_type, err_addr, err_cnt} !== 43'h0) begin
         n_fail++; $display("FAIL inflight_err: got %b/%b/%h/%0d expected 0", err, err_type, err_addr, err_cnt); end
      idle();
      repeat (2) @(posedge clk);
      #1 rst = 1;
      tick();
      n_chk++; if ({m_rd_vld, m_rd_data, err, err_cnt} !== 42'h0) begin
         n_fail++; $display("FAIL inflight_release: got %b/%h/%b/%0d expected 0", m_rd_vld, m_rd_data, err, err_cnt); end
   endtask

   initial begin
      c_base[0] = 32'h0000_0000; c_base[1] = 32'h1000_0000;
      c_base[2] = 32'h2000_0000; c_base[3] = 32'h3000_0000;
      test_reset();
      test_read_basic();
      test_dual();
      test_stall();
      test_errors();
      test_clr_coincident();
      test_saturation();
      test_random();
      test_reset_inflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/soc_bus_fabric.md
SOC_BUS_FABRIC -- requirements
Module: soc_bus_fabric

Interface
REQ-001 Parameter NUM_SLV, default 4, number of slave ports, legal range 1..8.
REQ-002 Parameter DATA_W, default 32, data width; ADDR_W, default 32, address width.
REQ-003 Parameter SLV_BASE, default {0x3000_0000,0x2000_0000,0x1000_0000,0x0000_0000}, packed NUM_SLV*ADDR_W; slot i is the base of slave i.
REQ-004 Parameter SLV_MASK, default 0xF000_0000 in every slot, packed NUM_SLV*ADDR_W; slot i is the mask of slave i.
REQ-005 Parameter ERR_DATA, default 0, read data returned for an unmapped read.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 m_rd_req_i, m_wr_req_i  in  1  master read and write requests.
REQ-009 m_rd_addr_i, m_wr_addr_i  in  ADDR_W  master read and write addresses.
REQ-010 m_wr_sel_i  in  4  write byte enables; m_wr_data_i  in  DATA_W  write data.
REQ-011 m_rd_data_o  out  DATA_W  read data; m_rd_vld_o  out  1  read data valid.
REQ-012 m_stall_o  out  1  master must hold its current requests.
REQ-013 s_rd_req_o, s_wr_req_o  out  NUM_SLV  one-hot per-slave requests.
REQ-014 s_rd_addr_o, s_wr_addr_o, s_wr_sel_o, s_wr_data_o  out  broadcast copies of the master fields.
REQ-015 s_rd_data_i  in  NUM_SLV*DATA_W  per-slave read data; s_busy_i  in  NUM_SLV  per-slave busy.
REQ-016 err_o  out  1  sticky error; err_type_o  out  2  error type, bit0 read, bit1 write.
REQ-017 err_addr_o  out  ADDR_W  address of the first error; err_cnt_o  out  8  error count.
REQ-018 err_clr_i  in  1  clears the error state.

Function
REQ-019 Decode SHALL be hit_i = ((addr & SLV_MASK[i]) == SLV_BASE[i]); if several slaves hit, the lowest index wins; if none hit, the access is unmapped.
REQ-020 Read and write SHALL be decoded independently; one read and one write in the same cycle are both legal.
REQ-021 m_stall_o SHALL equal (m_rd_req_i & busy of the read target) | (m_wr_req_i & busy of the write target); unmapped targets are never busy.
REQ-022 While m_stall_o=1, all bits of s_rd_req_o and s_wr_req_o SHALL be 0, and no error, counter or read-tracking state SHALL update.
REQ-023 An accepted request is one with req=1 and m_stall_o=0; it SHALL assert exactly one s_*_req_o bit, combinationally in the same cycle, or none if unmapped.
REQ-024 An accepted read SHALL register rd_idx_q (target index, or an unmapped flag) and set rd_vld_q=1 at the next edge; every other cycle, rd_vld_q SHALL clear.
REQ-025 m_rd_vld_o SHALL equal rd_vld_q, giving a fixed 1-cycle read latency.
REQ-026 When rd_vld_q=1, m_rd_data_o SHALL be s_rd_data_i[rd_idx_q], or ERR_DATA if unmapped.
REQ-027 When rd_vld_q=0, m_rd_data_o SHALL hold the last delivered value, so it is registered.
REQ-028 An accepted unmapped access with err_o=0 SHALL at the next edge set err_o, load err_addr_o and load err_type_o.
REQ-029 If both channels are unmapped in the same cycle, err_addr_o SHALL take the read address and err_type_o SHALL be 2'b11.
REQ-030 While err_o=1, err_addr_o and err_type_o SHALL freeze, so only the first error is captured.
REQ-031 err_cnt_o SHALL increment by 1 per cycle containing at least one accepted unmapped access, saturating at 0xFF.
REQ-032 err_clr_i=1 SHALL clear err_o, err_type_o, err_addr_o and err_cnt_o at the next edge.
REQ-033 If err_clr_i=1 and a new unmapped access occur in the same cycle, the new error SHALL win: err_o=1, the new address and type load, and err_cnt_o=1.

Reset
REQ-034 With rst=0, asynchronously: rd_vld_q=0, rd_idx_q=0, m_rd_data_o=0, err_o=0, err_type_o=0, err_addr_o=0, err_cnt_o=0.
REQ-035 A read in flight when reset asserts SHALL be discarded; no m_rd_vld_o pulse follows reset release.
REQ-036 The combinational outputs (s_*_req_o, m_stall_o) SHALL follow their inputs during reset.

Verification
REQ-037 Read 0x1000_0004 with s_rd_data_i[1]=0xCAFE_F00D -> s_rd_req_o=4'b0010 in the same cycle; next cycle m_rd_vld_o=1 and m_rd_data_o=0xCAFE_F00D.
REQ-038 Write 0x2000_0000 and read 0x0000_0010 in the same cycle -> s_wr_req_o=4'b0100 and s_rd_req_o=4'b0001; no stall.
REQ-039 s_busy_i[0]=1 for 3 cycles during a read of 0x0000_0000 -> m_stall_o=1 and s_rd_req_o=0 for 3 cycles; grant on cycle 4; data valid on cycle 5.
REQ-040 Unmapped read 0x5000_0000, then unmapped write 0x6000_0000 -> err_addr_o=0x5000_0000, err_type_o=2'b01 (frozen), err_cnt_o=2, and m_rd_data_o=ERR_DATA.
REQ-041 err_clr_i=1 coincident with an unmapped write to 0x7000_0000 -> err_o=1, err_addr_o=0x7000_0000, err_type_o=2'b10, err_cnt_o=1.
REQ-042 Assert rst=0 one cycle after an accepted read -> no m_rd_vld_o pulse; all registered outputs are 0.
